// File: rtl/emu_cmd_pkg.sv
// Shared definitions for the clk40 command frame scheduler: fixed frame
// words, the frame_src encoding, FSM state encoding and the per-slot grant
// vector.
package emu_cmd_pkg;

    // Frame words written when the scheduler itself originates the frame.
    localparam logic [15:0] SYNC_WORD = 16'h817E;
    localparam logic [15:0] IDLE_WORD = 16'h6969;

    // Source tag that travels with each registered frame on frame_src.
    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_SYNC = 3'd1,
        SRC_TRIG = 3'd2,
        SRC_A    = 3'd3,
        SRC_B    = 3'd4,
        SRC_IDLE = 3'd5
    } frame_src_e;

    // ARB: A and B compete round-robin.
    // BURST_A / BURST_B: one requester owns the command path until its
    // last frame transfers.
    typedef enum logic [1:0] {
        ST_ARB     = 2'd0,
        ST_BURST_A = 2'd1,
        ST_BURST_B = 2'd2
    } sched_state_e;

    // Round-robin pointer: names the requester that was served most
    // recently, so the other one wins the next tie.
    typedef enum logic {
        RR_A = 1'b0,
        RR_B = 1'b1
    } rr_e;

    // One-hot slot grant; at most one field is set in any cycle.
    typedef struct packed {
        logic sync;
        logic trig;
        logic a;
        logic b;
        logic idle;
    } grant_t;

endpackage

// File: rtl/cmd_sync_timer.sv
// Saturating counter of non-sync frames issued since the last sync frame.
// It comes out of reset saturated, so the first frame after reset is a sync.
// It never wraps: once it reaches SYNC_INTERVAL it holds there until a sync
// frame clears it.
module cmd_sync_timer
    import emu_cmd_pkg::*;
#(
    parameter int SYNC_INTERVAL = 32
) (
    input  logic clk40,
    input  logic rst_n,
    input  logic inc_i,   // a non-sync frame is issued this slot
    input  logic clr_i,   // a sync frame is issued this slot
    output logic due_o    // a sync frame must take the next open slot
);

    localparam int CW = $clog2(SYNC_INTERVAL + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(SYNC_INTERVAL);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign due_o = (cnt_q == CNT_MAX);

    // Next count: a clear wins over an increment; increments stop at CNT_MAX.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !due_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register; reset preloads the saturated value.
    always_ff @(posedge clk40) begin
        if (!rst_n) begin
            cnt_q <= CNT_MAX;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cmd_sched.sv
// Frame scheduler in front of the command_out FIFO (clk40 domain).
// Each slot it picks at most one 16-bit frame from: the periodic sync
// frame, the trigger requester, command requesters A (host) and
// B (auto-calibration), or idle fill. The chosen frame is registered onto
// datain/wr_cmd one cycle later.
//
// Handshake: every requester x follows valid/ready. x_ready is a
// combinational grant, high only in the cycle the slot goes to x; a frame
// transfers on the clk40 edge where x_valid && x_ready. Requesters hold
// x_data (and x_last) stable while x_valid is high. No ready is raised
// while fifo_full is high or while rst_n is low.
//
// The FIFO must assert fifo_full with at least one free entry left, since
// the write decided in the previous slot may already be in flight when
// full is sampled.
module cmd_sched
    import emu_cmd_pkg::*;
#(
    parameter int   SYNC_INTERVAL = 32,
    parameter logic IDLE_FILL     = 1'b1
) (
    input  logic        clk40,
    input  logic        rst_n,

    input  logic        trig_valid,
    input  logic [15:0] trig_data,
    output logic        trig_ready,

    input  logic        a_valid,
    input  logic [15:0] a_data,
    input  logic        a_last,
    output logic        a_ready,

    input  logic        b_valid,
    input  logic [15:0] b_data,
    input  logic        b_last,
    output logic        b_ready,

    input  logic        fifo_full,
    output logic        wr_cmd,
    output logic [15:0] datain,
    output logic [2:0]  frame_src,
    output logic        burst_active
);

    sched_state_e state_q;
    sched_state_e state_d;
    rr_e          rr_q;
    rr_e          rr_d;

    grant_t       gnt;
    logic         pick_a;
    logic         pick_b;
    logic         slot_open;
    logic         sync_due;
    logic         issue;

    logic [15:0]  frame_d;
    frame_src_e   src_d;

    logic         wr_cmd_q;
    logic [15:0]  datain_q;
    frame_src_e   src_q;

    // A slot can be used only out of reset and with FIFO headroom.
    assign slot_open = rst_n && !fifo_full;

    cmd_sync_timer #(
        .SYNC_INTERVAL (SYNC_INTERVAL)
    ) u_sync_timer (
        .clk40 (clk40),
        .rst_n (rst_n),
        .inc_i (gnt.trig | gnt.a | gnt.b | gnt.idle),
        .clr_i (gnt.sync),
        .due_o (sync_due)
    );

    // State register: FSM state and round-robin pointer.
    always_ff @(posedge clk40) begin
        if (!rst_n) begin
            state_q <= ST_ARB;
            rr_q    <= RR_A;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
        end
    end

    // Next-state: enter a burst on a non-last command frame, leave it on the
    // owner's last frame. The pointer records whoever was served last.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        case (state_q)
            ST_ARB: begin
                if (gnt.a) begin
                    rr_d    = RR_A;
                    state_d = a_last ? ST_ARB : ST_BURST_A;
                end else if (gnt.b) begin
                    rr_d    = RR_B;
                    state_d = b_last ? ST_ARB : ST_BURST_B;
                end
            end
            ST_BURST_A: begin
                if (gnt.a && a_last) begin
                    state_d = ST_ARB;
                end
            end
            ST_BURST_B: begin
                if (gnt.b && b_last) begin
                    state_d = ST_ARB;
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

    // Outputs of the FSM: which command requester is eligible in this state,
    // then the fixed slot priority sync > trig > command > idle.
    always_comb begin
        pick_a = 1'b0;
        pick_b = 1'b0;
        case (state_q)
            ST_ARB: begin
                if (a_valid && b_valid) begin
                    // Tie: the requester not served most recently wins.
                    pick_a = (rr_q == RR_B);
                    pick_b = (rr_q == RR_A);
                end else begin
                    pick_a = a_valid;
                    pick_b = b_valid;
                end
            end
            ST_BURST_A: pick_a = a_valid;
            ST_BURST_B: pick_b = b_valid;
            default: begin
                pick_a = 1'b0;
                pick_b = 1'b0;
            end
        endcase

        gnt = '0;
        if (slot_open) begin
            if (sync_due) begin
                gnt.sync = 1'b1;
            end else if (trig_valid) begin
                gnt.trig = 1'b1;
            end else if (pick_a) begin
                gnt.a = 1'b1;
            end else if (pick_b) begin
                gnt.b = 1'b1;
            end else if (IDLE_FILL) begin
                gnt.idle = 1'b1;
            end
        end
    end

    assign trig_ready   = gnt.trig;
    assign a_ready      = gnt.a;
    assign b_ready      = gnt.b;
    assign burst_active = (state_q == ST_BURST_A) || (state_q == ST_BURST_B);
    assign issue        = gnt.sync | gnt.trig | gnt.a | gnt.b | gnt.idle;

    // Frame mux: data word and source tag for the granted source.
    always_comb begin
        frame_d = datain_q;
        src_d   = SRC_NONE;
        if (gnt.sync) begin
            frame_d = SYNC_WORD;
            src_d   = SRC_SYNC;
        end else if (gnt.trig) begin
            frame_d = trig_data;
            src_d   = SRC_TRIG;
        end else if (gnt.a) begin
            frame_d = a_data;
            src_d   = SRC_A;
        end else if (gnt.b) begin
            frame_d = b_data;
            src_d   = SRC_B;
        end else if (gnt.idle) begin
            frame_d = IDLE_WORD;
            src_d   = SRC_IDLE;
        end
    end

    // Output register: one-cycle latency to the FIFO; datain holds when idle.
    always_ff @(posedge clk40) begin
        if (!rst_n) begin
            wr_cmd_q <= 1'b0;
            datain_q <= 16'h0000;
            src_q    <= SRC_NONE;
        end else begin
            wr_cmd_q <= issue;
            src_q    <= src_d;
            if (issue) begin
                datain_q <= frame_d;
            end
        end
    end

    assign wr_cmd    = wr_cmd_q;
    assign datain    = datain_q;
    assign frame_src = src_q;

endmodule

// File: tb/tb_cmd_sched.sv
// Directed bench for cmd_sched. Each slot step drives the requesters,
// checks the combinational readies on the falling edge, and pushes the
// frame it expects; a monitor pops one entry per cycle and compares it with
// the registered FIFO write that follows.
module tb_cmd_sched;

    localparam logic [15:0] SYNC_W = 16'h817E;
    localparam logic [15:0] IDLE_W = 16'h6969;
    localparam logic [2:0]  S_NONE = 3'd0;
    localparam logic [2:0]  S_SYNC = 3'd1;
    localparam logic [2:0]  S_TRIG = 3'd2;
    localparam logic [2:0]  S_A    = 3'd3;
    localparam logic [2:0]  S_B    = 3'd4;
    localparam logic [2:0]  S_IDLE = 3'd5;
    localparam int          W      = 20;

    logic        clk40;
    logic        rst_n;
    logic        trig_valid;
    logic [15:0] trig_data;
    logic        trig_ready;
    logic        a_valid;
    logic [15:0] a_data;
    logic        a_last;
    logic        a_ready;
    logic        b_valid;
    logic [15:0] b_data;
    logic        b_last;
    logic        b_ready;
    logic        fifo_full;
    logic        wr_cmd;
    logic [15:0] datain;
    logic [2:0]  frame_src;
    logic        burst_active;

    // {wr, src, data} expected from each slot decision, oldest first.
    logic [W-1:0] exp_q[$];
    int n_pass = 0;
    int n_chk  = 0;

    cmd_sched #(
        .SYNC_INTERVAL (32),
        .IDLE_FILL     (1'b1)
    ) dut (
        .clk40        (clk40),
        .rst_n        (rst_n),
        .trig_valid   (trig_valid),
        .trig_data    (trig_data),
        .trig_ready   (trig_ready),
        .a_valid      (a_valid),
        .a_data       (a_data),
        .a_last       (a_last),
        .a_ready      (a_ready),
        .b_valid      (b_valid),
        .b_data       (b_data),
        .b_last       (b_last),
        .b_ready      (b_ready),
        .fifo_full    (fifo_full),
        .wr_cmd       (wr_cmd),
        .datain       (datain),
        .frame_src    (frame_src),
        .burst_active (burst_active)
    );

    // Clock and reset
    initial clk40 = 1'b0;
    always #5 clk40 = ~clk40;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Monitor: each cycle, the registered output belongs to the oldest entry.
    always @(posedge clk40) begin
        logic [W-1:0] e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e[W-1]) begin
                chk("frame{wr,src,data}", {12'h0, wr_cmd, frame_src, datain}, {12'h0, e});
            end else begin
                chk("no_write", {31'h0, wr_cmd}, 32'h0);
            end
        end
    end

    // Driver tasks: called just after a rising edge, return just after the next.
    task automatic slot(input logic ewr, input logic [2:0] esrc, input logic [15:0] edat,
                        input logic [2:0] erdy, input string tag);
        @(negedge clk40);
        chk({tag, "_rdy{t,a,b}"}, {29'h0, trig_ready, a_ready, b_ready}, {29'h0, erdy});
        exp_q.push_back({ewr, esrc, edat});
        @(posedge clk40);
        #1;
    endtask

    task automatic slot_w(input logic [2:0] esrc, input logic [15:0] edat,
                          input logic [2:0] erdy, input string tag);
        slot(1'b1, esrc, edat, erdy, tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk40);
        chk("rst_rdy", {29'h0, trig_ready, a_ready, b_ready}, 32'h0);
        @(posedge clk40);
        #1;
        chk("rst_wr_cmd",    {31'h0, wr_cmd}, 32'h0);
        chk("rst_datain",    {16'h0, datain}, 32'h0);
        chk("rst_frame_src", {29'h0, frame_src}, 32'h0);
        chk("rst_burst",     {31'h0, burst_active}, 32'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        trig_valid = 1'b0;
        trig_data  = 16'h0000;
        a_valid    = 1'b0;
        a_data     = 16'h0000;
        a_last     = 1'b0;
        b_valid    = 1'b0;
        b_data     = 16'h0000;
        b_last     = 1'b0;
        fifo_full  = 1'b0;
        @(posedge clk40);
        #1;

        // Idle fill with a sync every 33 writes; trigger rises as sync falls due.
        do_reset();
        slot_w(S_SYNC, SYNC_W, 3'b000, "t1_sync0");
        for (int i = 1; i <= 32; i++) slot_w(S_IDLE, IDLE_W, 3'b000, "t1_idle");
        trig_valid = 1'b1;
        trig_data  = 16'h2B2B;
        slot_w(S_SYNC, SYNC_W, 3'b000, "t4_sync_first");
        slot_w(S_TRIG, 16'h2B2B, 3'b100, "t4_trig_next");
        trig_valid = 1'b0;
        slot_w(S_IDLE, IDLE_W, 3'b000, "t4_idle");

        // A and B both streaming single frames: B first, then alternating.
        a_valid = 1'b1; a_last = 1'b1; a_data = 16'h1001;
        b_valid = 1'b1; b_last = 1'b1; b_data = 16'h2001;
        do_reset();
        slot_w(S_SYNC, SYNC_W, 3'b000, "t2_sync");
        for (int i = 0; i < 3; i++) begin
            slot_w(S_B, b_data, 3'b001, "t2_b");
            b_data = b_data + 16'h1;
            slot_w(S_A, a_data, 3'b010, "t2_a");
            a_data = a_data + 16'h1;
        end
        a_valid = 1'b0;
        b_valid = 1'b0;

        // A 3-frame burst with B waiting and a trigger in the burst's 2nd slot.
        b_valid = 1'b1; b_data = 16'hB000; b_last = 1'b1;
        do_reset();
        slot_w(S_SYNC, SYNC_W, 3'b000, "t3_sync");
        slot_w(S_B, 16'hB000, 3'b001, "t3_b0");
        b_data  = 16'hB001;
        a_valid = 1'b1; a_data = 16'hA001; a_last = 1'b0;
        slot_w(S_A, 16'hA001, 3'b010, "t3_a1");
        a_data = 16'hA002;
        chk("t3_burst_on", {31'h0, burst_active}, 32'h1);
        trig_valid = 1'b1; trig_data = 16'h2B2B;
        slot_w(S_TRIG, 16'h2B2B, 3'b100, "t3_trig");
        trig_valid = 1'b0;
        slot_w(S_A, 16'hA002, 3'b010, "t3_a2");
        a_data = 16'hA003; a_last = 1'b1;
        chk("t3_burst_mid", {31'h0, burst_active}, 32'h1);
        slot_w(S_A, 16'hA003, 3'b010, "t3_a3");
        a_valid = 1'b0;
        chk("t3_burst_off", {31'h0, burst_active}, 32'h0);
        slot_w(S_B, 16'hB001, 3'b001, "t3_b1");
        b_data = 16'hB002;
        slot_w(S_B, 16'hB002, 3'b001, "t3_b2");
        b_valid = 1'b0;
        slot_w(S_IDLE, IDLE_W, 3'b000, "t3_idle");

        // FIFO full for 10 slots with A waiting (sync also held off).
        a_valid = 1'b1; a_data = 16'h3001; a_last = 1'b1;
        fifo_full = 1'b1;
        do_reset();
        for (int i = 0; i < 10; i++) slot(1'b0, S_NONE, 16'h0, 3'b000, "t5_full");
        fifo_full = 1'b0;
        slot_w(S_SYNC, SYNC_W, 3'b000, "t5_sync");
        slot_w(S_A, 16'h3001, 3'b010, "t5_a1");
        a_data = 16'h3002;
        slot_w(S_A, 16'h3002, 3'b010, "t5_a2");
        a_valid = 1'b0;
        slot_w(S_IDLE, IDLE_W, 3'b000, "t5_idle");

        // Reset in the middle of an A burst; B then wins arbitration.
        a_valid = 1'b1; a_data = 16'hC001; a_last = 1'b0;
        do_reset();
        slot_w(S_SYNC, SYNC_W, 3'b000, "t6_sync");
        slot_w(S_A, 16'hC001, 3'b010, "t6_a1");
        a_data  = 16'hC002;
        b_valid = 1'b1; b_data = 16'hD001; b_last = 1'b1;
        chk("t6_burst_on", {31'h0, burst_active}, 32'h1);
        slot_w(S_A, 16'hC002, 3'b010, "t6_a2_b_blocked");
        a_data = 16'hC003; a_last = 1'b1;
        do_reset();
        slot_w(S_SYNC, SYNC_W, 3'b000, "t6_sync_after_rst");
        slot_w(S_B, 16'hD001, 3'b001, "t6_b_wins");
        b_valid = 1'b0;
        slot_w(S_A, 16'hC003, 3'b010, "t6_a3");
        a_valid = 1'b0;

        // Sync counter saturates inside a long burst and sync preempts it.
        a_valid = 1'b1; a_data = 16'hE000; a_last = 1'b0;
        do_reset();
        slot_w(S_SYNC, SYNC_W, 3'b000, "t7_sync");
        for (int i = 0; i < 32; i++) begin
            slot_w(S_A, a_data, 3'b010, "t7_a");
            a_data = a_data + 16'h1;
        end
        chk("t7_burst_before", {31'h0, burst_active}, 32'h1);
        slot_w(S_SYNC, SYNC_W, 3'b000, "t7_sync_in_burst");
        chk("t7_burst_kept", {31'h0, burst_active}, 32'h1);
        a_last = 1'b1;
        slot_w(S_A, 16'hE020, 3'b010, "t7_a_last");
        a_valid = 1'b0;
        chk("t7_burst_off", {31'h0, burst_active}, 32'h0);
        slot_w(S_IDLE, IDLE_W, 3'b000, "t7_idle");

        // Final report
        @(posedge clk40);
        #3;
        chk("queue_drained", exp_q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
